tff_downcounter: RTL

Parameterised synchronous down-counter built from a chain of toggle flip-flop cells. It counts in the opposite direction to the team's ripple T-flip-flop up-counter and is fully synchronous: every bit shares one clock, and each bit's toggle enable is decoded from the lower bits. The block provides a parallel load, a zero flag and a one-cycle wrap pulse. It serves as a reloadable countdown timer or delay generator in the sequential-logic library.

---
 rtl/tff_counter_pkg.sv | 16 +
 rtl/tff_cell.sv | 27 ++
 rtl/tff_downcounter.sv | 69 ++++++
 3 files changed

// File: rtl/tff_counter_pkg.sv
// Shared constants and helpers for the T-flip-flop counter family.
package tff_counter_pkg;

    localparam int DEFAULT_WIDTH = 3;

    // All-ones reset pattern for a counter of the given width (up to 64 bits).
    function automatic logic [63:0] reset_value(input int width);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop bit with synchronous active-low reset and parallel load.
module tff_cell #(
    parameter logic RESET_Q = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q  <= RESET_Q;
            qn <= ~RESET_Q;
        end else if (ld) begin
            q  <= d;
            qn <= ~d;
        end else if (t) begin
            q  <= ~q;
            qn <= ~qn;
        end
    end

endmodule

// File: rtl/tff_downcounter.sv
// Synchronous down-counter built from tff_cell bits with load, zero flag and wrap pulse.
// Define TFF_DOWNCOUNTER_SATURATE_EN to make the count stop at zero instead of wrapping.
module tff_downcounter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             zero,
    output logic             wrap
);

    localparam logic [63:0]      RST_FULL = reset_value(WIDTH);
    localparam logic [WIDTH-1:0] RST_Q    = RST_FULL[WIDTH-1:0];

    logic             cnt_en;
    logic [WIDTH-1:0] t;

    assign zero = (q == '0);

`ifdef TFF_DOWNCOUNTER_SATURATE_EN
    assign cnt_en = en & ~zero;
`else
    assign cnt_en = en;
`endif

    // A bit toggles on decrement when every lower bit is zero (borrow ripples through).
    always_comb begin
        t[0] = cnt_en;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & ~q[i-1];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell #(
            .RESET_Q(RST_Q[i])
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .t    (t[i]),
            .ld   (load),
            .d    (load_val[i]),
            .q    (q[i]),
            .qn   (qn[i])
        );
    end

`ifdef TFF_DOWNCOUNTER_SATURATE_EN
    always_ff @(posedge clk) begin
        wrap <= 1'b0;
    end
`else
    always_ff @(posedge clk) begin
        if (!reset || load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= en & zero;
        end
    end
`endif

endmodule
